// File: rtl/encoder_serializer.sv
// Multi-hot to binary-index serializer: accepts a select vector and streams the
// index of every set bit, one per valid/ready handshake, in priority order.
module encoder_serializer #(
  parameter int N_IN      = 16,
  parameter int W_OUT     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  encoder_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W_OUT-1:0] encoder_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             empty_pulse
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state, state_next;
  logic [N_IN-1:0]   pending, pending_next;
  logic [W_OUT-1:0]  code_next;
  logic              last_next;
  logic              valid_next;
  logic              empty_next;

  function automatic logic [W_OUT-1:0] prio_index(input logic [N_IN-1:0] v);
    logic [W_OUT-1:0] idx;
    idx = '0;
    // Scan toward the preferred end so that the winning bit is assigned last.
    if (LSB_FIRST) begin
      for (int i = N_IN - 1; i >= 0; i--)
        if (v[i]) idx = W_OUT'(i);
    end else begin
      for (int i = 0; i < N_IN; i++)
        if (v[i]) idx = W_OUT'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      encoder_out <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      empty_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      pending     <= pending_next;
      encoder_out <= code_next;
      out_valid   <= valid_next;
      out_last    <= last_next;
      empty_pulse <= empty_next;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    empty_next   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (encoder_in != '0) begin
            pending_next = encoder_in;
            state_next   = EMIT;
          end else begin
            empty_next = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          // encoder_out always names the bit being handed over right now.
          pending_next = pending & ~(N_IN'(1) << encoder_out);
          if (pending_next == '0) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Outputs are precomputed from the next pending set so they can be registered.
    code_next  = prio_index(pending_next);
    last_next  = (pending_next != '0) &&
                 ((pending_next & (pending_next - N_IN'(1))) == '0);
    valid_next = (state_next == EMIT);
  end

  assign in_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_encoder_serializer.sv
// Directed bench for encoder_serializer: a queue-based model of the code stream
// checked every cycle, plus literal expectations for each directed scenario.
module tb_encoder_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] encoder_in;
  logic        in_valid;
  logic        out_ready;

  logic       in_ready0, out_valid0, out_last0, empty0;
  logic [3:0] out0;
  logic       in_ready1, out_valid1, out_last1, empty1;
  logic [3:0] out1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  encoder_serializer #(.N_IN(16), .W_OUT(4), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .encoder_in(encoder_in), .in_valid(in_valid),
    .in_ready(in_ready0), .encoder_out(out0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_last(out_last0), .empty_pulse(empty0)
  );

  encoder_serializer #(.N_IN(16), .W_OUT(4), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .encoder_in(encoder_in), .in_valid(in_valid),
    .in_ready(in_ready1), .encoder_out(out1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_last(out_last1), .empty_pulse(empty1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending codes as ordered queues; the head is the code on the bus.
  int  q_lsb[$];
  int  q_msb[$];
  bit  exp_empty = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q_lsb.delete();
      q_msb.delete();
      exp_empty = 1'b0;
    end else begin
      exp_empty = 1'b0;
      if (q_lsb.size() == 0) begin
        if (in_valid) begin
          if (encoder_in == 16'h0000) exp_empty = 1'b1;
          else
            for (int i = 0; i < 16; i++)
              if (encoder_in[i]) begin
                q_lsb.push_back(i);
                q_msb.push_front(i);
              end
        end
      end else if (out_ready) begin
        void'(q_lsb.pop_front());
        void'(q_msb.pop_front());
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    chk("model in_ready lsb", int'(in_ready0), int'(q_lsb.size() == 0 && !rst));
    chk("model in_ready msb", int'(in_ready1), int'(q_msb.size() == 0 && !rst));
    chk("model out_valid lsb", int'(out_valid0), int'(q_lsb.size() > 0));
    chk("model out_valid msb", int'(out_valid1), int'(q_msb.size() > 0));
    chk("model empty lsb", int'(empty0), int'(exp_empty));
    chk("model empty msb", int'(empty1), int'(exp_empty));
    if (q_lsb.size() > 0) begin
      chk("model code lsb", int'(out0), q_lsb[0]);
      chk("model last lsb", int'(out_last0), int'(q_lsb.size() == 1));
    end
    if (q_msb.size() > 0) begin
      chk("model code msb", int'(out1), q_msb[0]);
      chk("model last msb", int'(out_last1), int'(q_msb.size() == 1));
    end
  end

  // Advance to just after the model compare of the next cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic accept(input logic [15:0] vec);
    encoder_in = vec;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    encoder_in = 16'hDEAD;
  endtask

  initial begin
    rst = 1'b1; encoder_in = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("reset in_ready", int'(in_ready0), 0);
    chk("reset out_valid", int'(out_valid0), 0);
    chk("reset code", int'(out0), 0);
    chk("reset last", int'(out_last0), 0);
    chk("reset empty", int'(empty0), 0);
    rst = 1'b0;
    tick();
    chk("post-reset in_ready", int'(in_ready0), 1);

    // Single bit 0x0020
    accept(16'h0020);
    chk("single valid", int'(out_valid0), 1);
    chk("single code", int'(out0), 5);
    chk("single last", int'(out_last0), 1);
    chk("single in_ready", int'(in_ready0), 0);
    tick();
    chk("single done valid", int'(out_valid0), 0);
    chk("single done in_ready", int'(in_ready0), 1);

    // 0x8001: index 0 and 15, both orders
    accept(16'h8001);
    chk("ends code lsb0", int'(out0), 0);
    chk("ends last lsb0", int'(out_last0), 0);
    chk("ends code msb0", int'(out1), 15);
    chk("ends in_ready c1", int'(in_ready0), 0);
    tick();
    chk("ends code lsb1", int'(out0), 15);
    chk("ends last lsb1", int'(out_last0), 1);
    chk("ends code msb1", int'(out1), 0);
    chk("ends in_ready c2", int'(in_ready0), 0);
    tick();
    chk("ends in_ready c3", int'(in_ready0), 1);

    // Backpressure on 0x0011
    out_ready = 1'b0;
    accept(16'h0011);
    for (int c = 0; c < 5; c++) begin
      chk("stall code", int'(out0), 0);
      chk("stall last", int'(out_last0), 0);
      chk("stall valid", int'(out_valid0), 1);
      tick();
    end
    out_ready = 1'b1;
    chk("stall release code", int'(out0), 0);
    tick();
    chk("stall second code", int'(out0), 4);
    chk("stall second last", int'(out_last0), 1);
    tick();
    chk("stall done valid", int'(out_valid0), 0);

    // Zero vector
    accept(16'h0000);
    chk("zero empty", int'(empty0), 1);
    chk("zero valid", int'(out_valid0), 0);
    chk("zero in_ready", int'(in_ready0), 1);
    tick();
    chk("zero empty cleared", int'(empty0), 0);

    // Full vector 0xFFFF
    accept(16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      chk("full code lsb", int'(out0), i);
      chk("full last lsb", int'(out_last0), int'(i == 15));
      chk("full code msb", int'(out1), 15 - i);
      chk("full last msb", int'(out_last1), int'(i == 15));
      tick();
    end
    chk("full done valid", int'(out_valid0), 0);
    chk("full done in_ready", int'(in_ready0), 1);

    // Reset in the middle of 0x0F00
    accept(16'h0F00);
    chk("abort code 8", int'(out0), 8);
    tick();
    chk("abort code 9", int'(out0), 9);
    rst = 1'b1;
    #1;
    chk("abort async valid", int'(out_valid0), 0);
    chk("abort async in_ready", int'(in_ready0), 0);
    tick();
    chk("abort held in_ready", int'(in_ready0), 0);
    rst = 1'b0;
    tick();
    chk("abort release in_ready", int'(in_ready0), 1);
    for (int c = 0; c < 4; c++) begin
      chk("abort no codes", int'(out_valid0), 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
